// File: rtl/qpi_bus_arbiter_if.sv
// Shared QPI pad bus between two masters: per-master pin drives, grants and
// the muxed pad side. The arbiter takes the slave modport.
interface qpi_bus_arbiter_if;
    logic       m0_req, m1_req;
    logic       m0_gnt, m1_gnt;
    logic       m0_csb, m1_csb;
    logic       m0_clk, m1_clk;
    logic [3:0] m0_io_oe, m1_io_oe;
    logic [3:0] m0_io_do, m1_io_do;
    logic [3:0] m0_io_di, m1_io_di;
    logic [3:0] io_di;
    logic       qpi_clk;
    logic [3:0] qpi_io_oe, qpi_io_do;
    logic       flash_csb, ml_csb;
    logic       owner, busy, starve;

    modport slave (
        input  m0_req, m1_req, m0_csb, m1_csb, m0_clk, m1_clk,
               m0_io_oe, m1_io_oe, m0_io_do, m1_io_do, io_di,
        output m0_gnt, m1_gnt, m0_io_di, m1_io_di, qpi_clk, qpi_io_oe,
               qpi_io_do, flash_csb, ml_csb, owner, busy, starve
    );

    modport master (
        output m0_req, m1_req, m0_csb, m1_csb, m0_clk, m1_clk,
               m0_io_oe, m1_io_oe, m0_io_do, m1_io_do, io_di,
        input  m0_gnt, m1_gnt, m0_io_di, m1_io_di, qpi_clk, qpi_io_oe,
               qpi_io_do, flash_csb, ml_csb, owner, busy, starve
    );
endinterface

// File: rtl/qpi_bus_arbiter.sv
// Round-robin owner of the shared QPI pads (flash XIP vs ML accelerator) with
// an idle turnaround gap so the two chip selects can never overlap.
module qpi_bus_arbiter #(
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 4096
) (
    input  logic              clk,
    input  logic              resetn,
    qpi_bus_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;
    localparam logic [1:0] S_TURN = 2'd3;

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          fired_q, fired_d;
    logic [TW-1:0] turn_q, turn_d;

    logic own0, own1, owning, other_req, rel, starve_c;
    logic go, pick;

    assign own0      = (state_q == S_OWN0);
    assign own1      = (state_q == S_OWN1);
    assign owning    = own0 | own1;
    assign other_req = own0 ? bus.m1_req : bus.m0_req;
    // Release needs both req low and CSB back high, so a transfer is never cut.
    assign rel       = own0 ? (!bus.m0_req && bus.m0_csb) : (!bus.m1_req && bus.m1_csb);
    assign starve_c  = (MAX_HOLD != 0) && owning && (hold_q == HW'(MAX_HOLD))
                       && other_req && !fired_q;

    assign go   = bus.m0_req | bus.m1_req;
    assign pick = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        fired_d = fired_q;
        turn_d  = turn_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = pick ? S_OWN1 : S_OWN0;
                    last_d  = pick;
                    owner_d = pick;
                    hold_d  = '0;
                    fired_d = 1'b0;
                end
            end
            S_OWN0, S_OWN1: begin
                if (rel) begin
                    state_d = (TURN_CYCLES == 0) ? S_IDLE : S_TURN;
                    turn_d  = TW'(TURN_CYCLES - 1);
                end else begin
                    if (hold_q != HW'(MAX_HOLD)) hold_d = hold_q + 1'b1;
                    fired_d = fired_q | starve_c;
                end
            end
            default: begin
                if (turn_q == '0) state_d = S_IDLE;
                else              turn_d  = turn_q - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            hold_q  <= '0;
            fired_q <= 1'b0;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            fired_q <= fired_d;
            turn_q  <= turn_d;
        end
    end

    // Pads follow the owner combinationally; the non-owner is ignored entirely.
    assign bus.m0_gnt    = own0;
    assign bus.m1_gnt    = own1;
    assign bus.flash_csb = own0 ? bus.m0_csb : 1'b1;
    assign bus.ml_csb    = own1 ? bus.m1_csb : 1'b1;
    assign bus.qpi_clk   = own0 ? bus.m0_clk   : (own1 ? bus.m1_clk   : 1'b0);
    assign bus.qpi_io_oe = own0 ? bus.m0_io_oe : (own1 ? bus.m1_io_oe : 4'h0);
    assign bus.qpi_io_do = own0 ? bus.m0_io_do : (own1 ? bus.m1_io_do : 4'h0);
    assign bus.m0_io_di  = bus.io_di;
    assign bus.m1_io_di  = bus.io_di;
    assign bus.owner     = owner_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.starve    = starve_c;
endmodule

// File: tb/tb_qpi_bus_arbiter.sv
// Directed bench: dut_a (TURN_CYCLES=2) and dut_b (TURN_CYCLES=0), both MAX_HOLD=16.
module tb_qpi_bus_arbiter;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    qpi_bus_arbiter_if ia();
    qpi_bus_arbiter_if ib();

    qpi_bus_arbiter #(.TURN_CYCLES(2), .MAX_HOLD(16)) dut_a (.clk(clk), .resetn(resetn), .bus(ia));
    qpi_bus_arbiter #(.TURN_CYCLES(0), .MAX_HOLD(16)) dut_b (.clk(clk), .resetn(resetn), .bus(ib));

    typedef struct {
        string       tag;
        logic [15:0] exp;
        bit          b;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [15:0] mk(logic g0, g1, fc, mc, qc,
                                       logic [3:0] oe, dq, logic ow, bz, st);
        return {g0, g1, fc, mc, qc, oe, dq, ow, bz, st};
    endfunction

    function automatic logic [15:0] snap(bit b);
        if (b) return {ib.m0_gnt, ib.m1_gnt, ib.flash_csb, ib.ml_csb, ib.qpi_clk,
                       ib.qpi_io_oe, ib.qpi_io_do, ib.owner, ib.busy, ib.starve};
        return {ia.m0_gnt, ia.m1_gnt, ia.flash_csb, ia.ml_csb, ia.qpi_clk,
                ia.qpi_io_oe, ia.qpi_io_do, ia.owner, ia.busy, ia.starve};
    endfunction

    function automatic logic [15:0] idl(logic ow);
        return mk(0, 0, 1, 1, 0, 4'h0, 4'h0, ow, 0, 0);
    endfunction

    function automatic logic [15:0] trn(logic ow);
        return mk(0, 0, 1, 1, 0, 4'h0, 4'h0, ow, 1, 0);
    endfunction

    function automatic logic [15:0] o0(bit b, logic st);
        if (b) return mk(1, 0, ib.m0_csb, 1, ib.m0_clk, ib.m0_io_oe, ib.m0_io_do, 0, 1, st);
        return mk(1, 0, ia.m0_csb, 1, ia.m0_clk, ia.m0_io_oe, ia.m0_io_do, 0, 1, st);
    endfunction

    function automatic logic [15:0] o1(bit b, logic st);
        if (b) return mk(0, 1, 1, ib.m1_csb, ib.m1_clk, ib.m1_io_oe, ib.m1_io_do, 1, 1, st);
        return mk(0, 1, 1, ia.m1_csb, ia.m1_clk, ia.m1_io_oe, ia.m1_io_do, 1, 1, st);
    endfunction

    task automatic nxt();
        @(negedge clk);
    endtask

    // Push the expectation with the stimulus, then let outputs settle and drain.
    task automatic chk(string tag, logic [15:0] e, bit b = 1'b0);
        sb.push_back('{tag, e, b});
        #1;
        while (sb.size() > 0) begin
            exp_t        x;
            logic [15:0] o;
            x = sb.pop_front();
            o = snap(x.b);
            n_cmp++;
            assert (o === x.exp) else begin
                n_err++;
                $error("FAIL %s: got %h expected %h", x.tag, o, x.exp);
            end
        end
    endtask

    // The two chip selects must never be low together on either instance.
    always @(negedge clk) begin
        n_cmp++;
        assert (!(ia.flash_csb === 1'b0 && ia.ml_csb === 1'b0) &&
                !(ib.flash_csb === 1'b0 && ib.ml_csb === 1'b0)) else begin
            n_err++;
            $error("FAIL csb_overlap: a=%b%b b=%b%b expected no 00",
                   ia.flash_csb, ia.ml_csb, ib.flash_csb, ib.ml_csb);
        end
    end

    initial begin
        resetn = 1'b0;
        {ia.m0_req, ia.m1_req, ia.m0_clk, ia.m1_clk} = '0;
        {ia.m0_csb, ia.m1_csb} = 2'b11;
        {ia.m0_io_oe, ia.m1_io_oe, ia.m0_io_do, ia.m1_io_do, ia.io_di} = '0;
        {ib.m0_req, ib.m1_req, ib.m0_clk, ib.m1_clk} = '0;
        {ib.m0_csb, ib.m1_csb} = 2'b11;
        {ib.m0_io_oe, ib.m1_io_oe, ib.m0_io_do, ib.m1_io_do, ib.io_di} = '0;

        repeat (2) nxt();
        chk("rst_a", idl(0), 0);
        chk("rst_b", idl(0), 1);
        resetn = 1'b1;

        ia.io_di = 4'hC;
        #1;
        n_cmp++;
        assert ({ia.m0_io_di, ia.m1_io_di} === 8'hCC) else begin
            n_err++;
            $error("FAIL io_di_fanout: got %h expected cc", {ia.m0_io_di, ia.m1_io_di});
        end

        // dut_b: no turnaround, single idle cycle between owners
        nxt(); ib.m0_req = 1; ib.m1_req = 1;
        chk("b_idle_req", idl(0), 1);
        nxt(); ib.m0_csb = 0; ib.m0_clk = 1; ib.m0_io_oe = 4'h3; ib.m0_io_do = 4'h2;
        chk("b_own0", o0(1, 0), 1);
        nxt(); ib.m0_req = 0; ib.m0_csb = 1; ib.m0_clk = 0;
        chk("b_own0_rel", o0(1, 0), 1);
        nxt(); chk("b_gap", idl(0), 1);
        nxt(); ib.m1_csb = 0; ib.m1_clk = 1; ib.m1_io_oe = 4'h5; ib.m1_io_do = 4'h7;
        chk("b_own1", o1(1, 0), 1);
        nxt(); ib.m1_req = 0; ib.m1_csb = 1;
        chk("b_own1_rel", o1(1, 0), 1);
        nxt(); chk("b_idle_end", idl(1), 1);

        // dut_a: single request, latency and pad follow
        nxt(); ia.m0_req = 1;
        chk("a_req_lat", idl(0));
        nxt(); chk("a_gnt", o0(0, 0));
        ia.m0_csb = 0; ia.m0_clk = 1; ia.m0_io_oe = 4'hF; ia.m0_io_do = 4'hA;
        ia.m1_csb = 0; ia.m1_clk = 1; ia.m1_io_oe = 4'hF; ia.m1_io_do = 4'h5;
        chk("a_follow", o0(0, 0));

        // premature req drop with CSB still low keeps ownership
        nxt(); ia.m0_req = 0;
        chk("a_drop0", o0(0, 0));
        for (int i = 1; i < 5; i++) begin
            nxt(); ia.m0_io_do = 4'(i);
            chk($sformatf("a_drop%0d", i), o0(0, 0));
        end
        nxt(); ia.m0_csb = 1;
        chk("a_csb_hi", o0(0, 0));
        ia.m1_csb = 1; ia.m1_clk = 0; ia.m1_io_oe = 4'h0; ia.m1_io_do = 4'h0;
        nxt(); chk("a_turn1", trn(0));
        nxt(); chk("a_turn2", trn(0));
        nxt(); chk("a_idle", idl(0));

        // contention after reset: m0 first, then alternation
        nxt(); resetn = 0;
        nxt(); resetn = 1;
        chk("a_rst2", idl(0));
        ia.m0_req = 1; ia.m1_req = 1; ia.m0_csb = 1; ia.m1_csb = 1;
        nxt(); chk("a_cont_m0", o0(0, 0));
        ia.m0_csb = 0;
        for (int i = 0; i < 3; i++) begin
            nxt(); chk("a_cont_hold", o0(0, 0));
        end
        nxt(); ia.m0_req = 0; ia.m0_csb = 1;
        chk("a_cont_rel", o0(0, 0));
        nxt(); chk("a_cont_t1", trn(0));
        nxt(); chk("a_cont_t2", trn(0));
        nxt(); chk("a_cont_idle", idl(0));
        nxt(); ia.m1_csb = 0; ia.m1_clk = 1; ia.m1_io_oe = 4'h9; ia.m1_io_do = 4'h6;
        ia.m0_req = 1; ia.m0_csb = 0;
        chk("a_cont_m1", o1(0, 0));
        nxt(); chk("a_m1_hold", o1(0, 0));
        nxt(); ia.m1_req = 0; ia.m1_csb = 1;
        chk("a_m1_rel", o1(0, 0));
        nxt(); chk("a_m1_t1", trn(1));
        nxt(); chk("a_m1_t2", trn(1));
        nxt(); chk("a_m1_idle", idl(1));
        nxt(); chk("a_alt_m0", o0(0, 0));
        nxt(); ia.m0_req = 0; ia.m0_csb = 1;
        chk("a_alt_rel", o0(0, 0));
        nxt(); chk("a_alt_t1", trn(0));
        nxt(); chk("a_alt_t2", trn(0));
        nxt(); chk("a_alt_idle", idl(0));

        // starvation: one pulse in ownership cycle 17, no revoke
        nxt(); ia.m0_req = 1;
        chk("a_st_req", idl(0));
        for (int k = 1; k <= 40; k++) begin
            nxt();
            if (k == 1) begin ia.m1_req = 1; ia.m0_csb = 0; end
            if (k == 40) begin ia.m0_req = 0; ia.m0_csb = 1; end
            chk($sformatf("a_hold%0d", k), o0(0, k == 17));
        end
        nxt(); chk("a_st_t1", trn(0));
        nxt(); chk("a_st_t2", trn(0));
        nxt(); chk("a_st_idle", idl(0));
        nxt(); ia.m1_csb = 0;
        chk("a_st_served", o1(0, 0));

        // reset mid-transaction while ml_csb is low
        nxt(); resetn = 0;
        chk("a_rst_pre", o1(0, 0));
        nxt(); chk("a_rst_mid", idl(0));
        resetn = 1; ia.m0_req = 1; ia.m0_csb = 1;
        nxt(); chk("a_rst_m0wins", o0(0, 0));

        nxt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
